// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32x32 register file with busy scoreboard and issue hazard stall
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   rs1_addr/rs1_data             read port 1 (ALU operand_a), combinational, wb bypassed
//   rs2_addr/rs2_data             read port 2 (ALU operand_b), combinational, wb bypassed
//   wb_en/wb_addr/wb_data         ALU result writeback; also clears busy[wb_addr]
//   issue_valid/issue_rd/...used  instruction presented by the issue stage
//   stall, issue_fire             RAW/WAW hold and accepted-issue strobe
//   busy                          per-register write-pending bits
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             issue_rd_used,
  input  logic             issue_rs1_used,
  input  logic             issue_rs2_used,
  output logic             stall,
  output logic             issue_fire,
  output logic [NREGS-1:0] busy
);

  localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] ebusy;
  logic             wb_live;
  logic             raw1, raw2, waw;

  // A writeback to x0 is a no-op everywhere, including the bypass path.
  assign wb_live = wb_en && (wb_addr != '0);

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (wb_live && (wb_addr == rs1_addr))
      rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == '0)
      rs2_data = '0;
    else if (wb_live && (wb_addr == rs2_addr))
      rs2_data = wb_data;
  end

  // Same-cycle writeback resolves the hazard, so stall looks at busy minus the
  // register being written right now.
  assign wb_mask = wb_en ? (ONE << wb_addr) : '0;
  assign ebusy   = busy_q & ~wb_mask;

  assign raw1 = issue_rs1_used & ebusy[rs1_addr];
  assign raw2 = issue_rs2_used & ebusy[rs2_addr];
  assign waw  = issue_rd_used  & ebusy[issue_rd];

  // busy_q is zero while in reset, so stall is already 0 then; issue_fire is
  // gated explicitly so nothing is accepted during reset.
  assign stall      = issue_valid & (raw1 | raw2 | waw);
  assign issue_fire = issue_valid & ~stall & rst_n;

  assign set_mask = (issue_fire && issue_rd_used && (issue_rd != '0)) ? (ONE << issue_rd) : '0;

  assign busy = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      // Set after clear: a new producer issued on the retiring edge owns the register.
      busy_q <= ((busy_q & ~wb_mask) | set_mask) & ~ONE;
      if (wb_live)
        regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, wb_addr, issue_rd;
  logic [31:0] rs1_data, rs2_data, wb_data, busy;
  logic        wb_en, issue_valid, issue_rd_used, issue_rs1_used, issue_rs2_used;
  logic        stall, issue_fire;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rd_used(issue_rd_used), .issue_rs1_used(issue_rs1_used),
    .issue_rs2_used(issue_rs2_used),
    .stall(stall), .issue_fire(issue_fire), .busy(busy)
  );

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs1, rs2;
    logic        iv;
    logic [4:0]  rd;
    logic        rd_u, r1_u, r2_u;
    logic [31:0] e_rs1, e_rs2;
    logic        e_stall, e_fire;
    logic [31:0] e_busy;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] e_rs1, e_rs2;
    logic        e_stall, e_fire;
    logic [31:0] e_busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic iv, input logic [4:0] rd,
                              input logic rdu, input logic r1u, input logic r2u,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic es, input logic ef, input logic [31:0] eb);
    vec_t v;
    v.wb_en = we; v.wb_addr = wa; v.wb_data = wd; v.rs1 = r1; v.rs2 = r2;
    v.iv = iv; v.rd = rd; v.rd_u = rdu; v.r1_u = r1u; v.r2_u = r2u;
    v.e_rs1 = e1; v.e_rs2 = e2; v.e_stall = es; v.e_fire = ef; v.e_busy = eb;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic iv, input logic [4:0] rd,
                       input logic rdu, input logic r1u, input logic r2u);
    wb_en = we; wb_addr = wa; wb_data = wd; rs1_addr = r1; rs2_addr = r2;
    issue_valid = iv; issue_rd = rd; issue_rd_used = rdu;
    issue_rs1_used = r1u; issue_rs2_used = r2u;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_busy;
    exp_t e;

    // Each row is one cycle; expectations are the pre-edge view of that cycle.
    //          we  wa  wd            r1  r2  iv rd  rdu r1u r2u  e_rs1         e_rs2         st fi busy
    vecs.push_back(mk(0, 0, 32'h0,        0,  0,  0, 0,  0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(1, 7, 32'hDEADBEEF, 1,  2,  0, 0,  0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0,  7,  0, 0,  0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 0,  0,  0, 0,  0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0,  7,  0, 0,  0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3, 32'h80000000, 3,  3,  0, 0,  0, 0, 0, 32'h80000000, 32'h80000000, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        3,  0,  1, 4,  1, 0, 0, 32'h80000000, 32'h0,        0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        4,  0,  1, 0,  0, 1, 0, 32'h0,        32'h0,        1, 0, 32'h10));
    vecs.push_back(mk(0, 0, 32'h0,        4,  0,  1, 0,  0, 1, 0, 32'h0,        32'h0,        1, 0, 32'h10));
    vecs.push_back(mk(1, 4, 32'h11112222, 4,  0,  1, 0,  0, 1, 0, 32'h11112222, 32'h0,        0, 1, 32'h10));
    vecs.push_back(mk(0, 0, 32'h0,        0,  4,  1, 9,  1, 0, 0, 32'h0,        32'h11112222, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0,  0,  1, 9,  1, 0, 0, 32'h0,        32'h0,        1, 0, 32'h200));
    vecs.push_back(mk(1, 9, 32'h0000ABCD, 0,  0,  1, 9,  1, 0, 0, 32'h0,        32'h0,        0, 1, 32'h200));
    vecs.push_back(mk(0, 0, 32'h0,        9,  4,  0, 0,  0, 0, 0, 32'h0000ABCD, 32'h11112222, 0, 0, 32'h200));
    vecs.push_back(mk(1, 5, 32'h12345678, 5,  9,  0, 0,  0, 0, 0, 32'h12345678, 32'h0000ABCD, 0, 0, 32'h200));
    vecs.push_back(mk(0, 0, 32'h0,        5,  0,  0, 0,  0, 0, 0, 32'h12345678, 32'h0,        0, 0, 32'h200));

    drive(0, 0, 0, 0, 0, 1, 3, 1, 1, 1);
    rst_n = 1'b0;
    #2;
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_fire", {31'b0, issue_fire}, 32'h0);
    chk("reset_busy", busy, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data, vecs[i].rs1, vecs[i].rs2,
            vecs[i].iv, vecs[i].rd, vecs[i].rd_u, vecs[i].r1_u, vecs[i].r2_u);
      e.name = $sformatf("vec%0d", i);
      e.e_rs1 = vecs[i].e_rs1; e.e_rs2 = vecs[i].e_rs2;
      e.e_stall = vecs[i].e_stall; e.e_fire = vecs[i].e_fire; e.e_busy = vecs[i].e_busy;
      sb.push_back(e);
      #3;
      e = sb.pop_front();
      chk({e.name, "_rs1_data"}, rs1_data, e.e_rs1);
      chk({e.name, "_rs2_data"}, rs2_data, e.e_rs2);
      chk({e.name, "_stall"}, {31'b0, stall}, {31'b0, e.e_stall});
      chk({e.name, "_fire"}, {31'b0, issue_fire}, {31'b0, e.e_fire});
      chk({e.name, "_busy"}, busy, e.e_busy);
      next_cycle();
    end
    chk("busy_set_wins_x9", busy, 32'h200);

    // Fill the scoreboard: every register except x0 (and the already busy x9).
    exp_busy = 32'h200;
    for (int r = 1; r < 32; r++) begin
      if (r != 9) begin
        drive(0, 0, 0, 0, 0, 1, 5'(r), 1, 0, 0);
        #3;
        chk($sformatf("fill_fire_x%0d", r), {31'b0, issue_fire}, 32'h1);
        exp_busy = exp_busy | (32'h1 << r);
        next_cycle();
      end
    end
    chk("busy_full", busy, exp_busy);
    chk("busy_full_const", busy, 32'hFFFF_FFFE);

    drive(0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    #3;
    chk("x0_no_stall", {31'b0, stall}, 32'h0);
    chk("x0_fire", {31'b0, issue_fire}, 32'h1);
    next_cycle();
    chk("x0_busy_unchanged", busy, 32'hFFFF_FFFE);

    drive(0, 0, 0, 5, 0, 1, 0, 0, 1, 0);
    #3;
    chk("raw_x5_stall", {31'b0, stall}, 32'h1);
    issue_valid = 1'b0;
    #1;
    chk("idle_stall", {31'b0, stall}, 32'h0);
    chk("idle_fire", {31'b0, issue_fire}, 32'h0);
    next_cycle();

    // Writeback to x5 resolves the RAW in the same cycle and clears busy[5].
    drive(1, 5, 32'h12345678, 5, 6, 1, 0, 0, 1, 0);
    #3;
    chk("wb_resolve_stall", {31'b0, stall}, 32'h0);
    chk("wb_resolve_fire", {31'b0, issue_fire}, 32'h1);
    chk("wb_resolve_bypass", rs1_data, 32'h12345678);
    next_cycle();
    chk("wb_clear_busy", busy, 32'hFFFF_FFDE);

    // Asynchronous reset mid-cycle.
    drive(0, 0, 0, 5, 0, 1, 7, 1, 1, 0);
    #1;
    chk("pre_reset_x5", rs1_data, 32'h12345678);
    rst_n = 1'b0;
    #1;
    chk("async_reset_x5", rs1_data, 32'h0);
    chk("async_reset_busy", busy, 32'h0);
    chk("async_reset_stall", {31'b0, stall}, 32'h0);
    chk("async_reset_fire", {31'b0, issue_fire}, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 5, 7, 0, 0, 0, 0, 0);
    #2;
    chk("post_reset_x5", rs1_data, 32'h0);
    chk("post_reset_x7", rs2_data, 32'h0);
    chk("post_reset_busy", busy, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32 x 32-bit integer register file with a per-register busy scoreboard.
- Supplies the ALU operand_a/operand_b source values (rs1/rs2 read data) and accepts ALU results back through a single writeback port.
- Sits between decode/issue and the ALU: it is the operand producer and the result consumer for the ALU datapath.
- Raises a stall to the issue stage on RAW or WAW hazards against results not yet written back.

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- NREGS, 32, number of architectural registers; x0 is always zero.
- AW, 5, register address width; must equal clog2(NREGS).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr  in  AW  read port 1 address (ALU operand_a source).
- rs2_addr  in  AW  read port 2 address (ALU operand_b source).
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_data  out  XLEN  read port 2 data, combinational.
- wb_en  in  1  writeback strobe for the ALU result.
- wb_addr  in  AW  writeback destination register.
- wb_data  in  XLEN  writeback value (ALU result).
- issue_valid  in  1  issue stage presents an instruction this cycle.
- issue_rd  in  AW  destination of the presented instruction.
- issue_rd_used  in  1  instruction writes rd.
- issue_rs1_used  in  1  instruction reads rs1_addr.
- issue_rs2_used  in  1  instruction reads rs2_addr.
- stall  out  1  instruction must not issue this cycle.
- issue_fire  out  1  equals issue_valid & ~stall.
- busy  out  NREGS  scoreboard vector; bit i set means register i has a write pending.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers are 0 and busy is 0. While reset is asserted, stall=0, issue_fire=0, and read data shows the bypassed or stored value (0 unless wb is active).
- x0: writes to address 0 are discarded. Reads of address 0 return 0 even when wb_addr=0. busy[0] is always 0.
- Write: on the rising edge with wb_en=1 and wb_addr!=0, reg[wb_addr] takes wb_data. Latency is 1 cycle; the stored value is visible from the next cycle.
- Read bypass: if wb_en=1, wb_addr!=0 and wb_addr==rsN_addr, then rsN_data=wb_data in the same cycle. Otherwise rsN_data=reg[rsN_addr].
- Both read ports may address the same register; both return identical data.
- Scoreboard clear: on an edge with wb_en=1, busy[wb_addr] is cleared.
- Scoreboard set: on an edge with issue_fire=1, issue_rd_used=1 and issue_rd!=0, busy[issue_rd] is set.
- Same register set and cleared on the same edge: set wins, so the new producer owns the register.
- Effective busy: ebusy[i] = busy[i] & ~(wb_en & wb_addr==i). A writeback in the current cycle resolves the hazard in that same cycle.
- Stall: stall = issue_valid & (RAW1 | RAW2 | WAW), where
  - RAW1 = issue_rs1_used & ebusy[rs1_addr]
  - RAW2 = issue_rs2_used & ebusy[rs2_addr]
  - WAW = issue_rd_used & ebusy[issue_rd]
- Address 0 never causes a stall.
- issue_valid=0 forces stall=0.
- wb_en to a register that is not busy is legal: data is written and busy is unchanged.
- No internal FSM beyond the scoreboard bits. All outputs other than busy are combinational from the inputs and state.

Test Plan:
- Reset value: assert rst_n=0 mid-run after writing x5=32'h1234_5678 -> rs1_addr=5 reads 0 and busy=0 immediately, without waiting for a clock edge.
- Write then read:
  - wb x7=32'hDEAD_BEEF -> next cycle rs2_addr=7 returns DEADBEEF.
  - wb x0=32'hFFFF_FFFF -> rs1_addr=0 returns 0.
- Bypass: same cycle wb_en=1, wb_addr=3, wb_data=32'h8000_0000, rs1_addr=rs2_addr=3 -> both read data outputs equal 80000000 before the edge.
- RAW stall: issue rd=4 (fires, busy[4]=1); next cycle issue rs1=4 -> stall=1 each cycle until the wb to x4 cycle, where stall=0 and rs1_data=wb_data.
- WAW and set-wins:
  - busy[9]=1 and issue rd=9 with no wb -> stall=1.
  - Same cycle wb_addr=9 and issue rd=9 -> stall=0, issue_fire=1, and busy[9] remains 1 after the edge.
- x0 and idle: issue rd=0, rs1=0, rs2=0 with busy full except bit 0 -> stall=0. With issue_valid=0 -> stall=0 and issue_fire=0.
